// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: data widths and the MEM/WB latch layout.
package mem_stage_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  // MEM/WB control and passthrough fields; the loaded word comes straight from the RAM
  // read register and is qualified by load_sel.
  typedef struct packed {
    logic [WORD_W-1:0]     alu_result;
    logic [REG_ADDR_W-1:0] write_register;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  misaligned;
    logic                  load_sel;
  } memwb_t;

  localparam memwb_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/mem_stage_data_memory.sv
// Simple dual-port synchronous RAM: port A read/write for the stage, port B read-only debug.
// Both read ports return the value held before any same-edge write.
module mem_stage_data_memory
  import mem_stage_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] i_a_addr,
  input  logic                 i_a_we,
  input  logic                 i_a_re,
  input  logic [WORD_W-1:0]    i_a_wdata,
  output logic [WORD_W-1:0]    o_a_rdata,
  input  logic [ADDR_BITS-1:0] i_b_addr,
  output logic [WORD_W-1:0]    o_b_rdata
);

  logic [WORD_W-1:0] r_mem [MEM_DEPTH];

  // Storage write plus registered reads on both ports.
  always_ff @(posedge clk) begin
    if (i_a_we) begin
      r_mem[i_a_addr] <= i_a_wdata;
    end
    if (i_a_re) begin
      o_a_rdata <= r_mem[i_a_addr];
    end
    o_b_rdata <= r_mem[i_b_addr];
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory access with configurable latency, stall FSM and MEM/WB latch.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_W-1:0]     alu_result_in,
  input  logic [WORD_W-1:0]     read_data_2_in,
  input  logic [REG_ADDR_W-1:0] write_register_in,
  input  logic                  reg_write_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  mem_to_reg_in,
  output logic                  stall_out,
  output logic [WORD_W-1:0]     read_data_out,
  output logic [WORD_W-1:0]     alu_result_out,
  output logic [REG_ADDR_W-1:0] write_register_out,
  output logic                  reg_write_out,
  output logic                  mem_to_reg_out,
  output logic                  misaligned_out,
  input  logic [ADDR_BITS-1:0]  dbg_addr,
  output logic [WORD_W-1:0]     dbg_data
);

  localparam int unsigned CNT_W = $clog2(MEM_LATENCY) + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_stall;
  logic             w_complete;
  logic             w_mem_op;
  logic             w_mis;
  logic             w_we;
  logic             w_re;
  logic [WORD_W-1:0] w_a_rdata;
  memwb_t           r_memwb;

  assign w_mem_op = mem_read_in | mem_write_in;
  assign w_mis    = w_mem_op & (alu_result_in[1:0] != 2'b00);

  // Store wins over a simultaneous load; reset drops a store due on this edge.
  assign w_we = w_complete & mem_write_in & ~w_mis & ~reset;
  assign w_re = w_complete & mem_read_in & ~mem_write_in & ~w_mis;

  // Next-state logic: IDLE/BUSY with a down-counter of remaining stall cycles.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_stall      = 1'b0;
    w_complete   = 1'b0;
    if (r_state == ST_IDLE) begin
      if (w_mem_op) begin
        if (MEM_LATENCY == 1) begin
          w_complete = 1'b1;
        end else begin
          w_stall      = 1'b1;
          w_state_next = ST_BUSY;
          w_cnt_next   = CNT_W'(MEM_LATENCY - 2);
        end
      end
    end else begin
      if (r_cnt != '0) begin
        w_stall    = 1'b1;
        w_cnt_next = r_cnt - CNT_W'(1);
      end else begin
        w_complete   = 1'b1;
        w_state_next = ST_IDLE;
      end
    end
  end

  // Reset forces the stall low in the same cycle so upstream is released immediately.
  assign stall_out = w_stall & ~reset;

  // FSM state and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // MEM/WB latch: bubble while stalled, otherwise capture the instruction.
  always_ff @(posedge clk) begin
    if (reset || w_stall) begin
      r_memwb <= MEMWB_BUBBLE;
    end else begin
      r_memwb.alu_result     <= alu_result_in;
      r_memwb.write_register <= write_register_in;
      r_memwb.reg_write      <= reg_write_in & ~w_mis;
      r_memwb.mem_to_reg     <= mem_to_reg_in;
      r_memwb.misaligned     <= w_mis;
      r_memwb.load_sel       <= w_re;
    end
  end

  mem_stage_data_memory #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_data_memory (
    .clk       (clk),
    .i_a_addr  (alu_result_in[ADDR_BITS+1:2]),
    .i_a_we    (w_we),
    .i_a_re    (w_re),
    .i_a_wdata (read_data_2_in),
    .o_a_rdata (w_a_rdata),
    .i_b_addr  (dbg_addr),
    .o_b_rdata (dbg_data)
  );

  assign read_data_out      = r_memwb.load_sel ? w_a_rdata : '0;
  assign alu_result_out     = r_memwb.alu_result;
  assign write_register_out = r_memwb.write_register;
  assign reg_write_out      = r_memwb.reg_write;
  assign mem_to_reg_out     = r_memwb.mem_to_reg;
  assign misaligned_out     = r_memwb.misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: three instances with latency 1, 3 and 4.
module tb_mem_stage;

  typedef struct {
    int          inst;
    int          cyc;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        rw;
    logic        m2r;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst    [3];
  logic [31:0] alu_in [3];
  logic [31:0] rd2_in [3];
  logic [4:0]  wr_in  [3];
  logic        rw_in  [3];
  logic        mr_in  [3];
  logic        mw_in  [3];
  logic        m2r_in [3];
  logic [7:0]  dbg_a  [3];
  logic        stall_o[3];
  logic [31:0] rd_o   [3];
  logic [31:0] alu_o  [3];
  logic [4:0]  wr_o   [3];
  logic        rw_o   [3];
  logic        m2r_o  [3];
  logic        mis_o  [3];
  logic [31:0] dbg_o  [3];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_stage #(
      .MEM_DEPTH   (256),
      .ADDR_BITS   (8),
      .MEM_LATENCY ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clk                (clk),
      .reset              (rst[g]),
      .alu_result_in      (alu_in[g]),
      .read_data_2_in     (rd2_in[g]),
      .write_register_in  (wr_in[g]),
      .reg_write_in       (rw_in[g]),
      .mem_read_in        (mr_in[g]),
      .mem_write_in       (mw_in[g]),
      .mem_to_reg_in      (m2r_in[g]),
      .stall_out          (stall_o[g]),
      .read_data_out      (rd_o[g]),
      .alu_result_out     (alu_o[g]),
      .write_register_out (wr_o[g]),
      .reg_write_out      (rw_o[g]),
      .mem_to_reg_out     (m2r_o[g]),
      .misaligned_out     (mis_o[g]),
      .dbg_addr           (dbg_a[g]),
      .dbg_data           (dbg_o[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int k);
    alu_in[k] = '0; rd2_in[k] = '0; wr_in[k] = '0;
    rw_in[k]  = 1'b0; mr_in[k] = 1'b0; mw_in[k] = 1'b0; m2r_in[k] = 1'b0;
  endtask

  // Present one instruction, queue its MEM/WB result, check the stall pattern cycle by cycle.
  task automatic issue(input int k, input logic [31:0] alu, input logic [31:0] rd2,
                       input logic [4:0] wr, input logic rw, input logic mr, input logic mw,
                       input logic m2r, input logic [31:0] e_rd, input logic e_rw,
                       input logic e_mis);
    exp_t e;
    int   lat;
    lat = lat_of(k);
    alu_in[k] = alu; rd2_in[k] = rd2; wr_in[k] = wr;
    rw_in[k] = rw; mr_in[k] = mr; mw_in[k] = mw; m2r_in[k] = m2r;
    e.inst = k; e.cyc = cyc + lat; e.rd = e_rd; e.alu = alu; e.wr = wr;
    e.rw = e_rw; e.m2r = m2r; e.mis = e_mis;
    sb_q.push_back(e);
    for (int j = 0; j < lat; j++) begin
      @(negedge clk);
      chk($sformatf("stall[%0d] cycle %0d", k, j), 32'(stall_o[k]),
          (j < lat - 1) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    idle(k);
  endtask

  task automatic dbg(input int k, input logic [7:0] a, input logic [31:0] exp);
    dbg_a[k] = a;
    @(posedge clk);
    #1;
    chk($sformatf("dbg[%0d] addr %0d", k, a), dbg_o[k], exp);
  endtask

  // Monitor: any non-bubble MEM/WB content must match the head of the scoreboard.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (|{rd_o[k], alu_o[k], wr_o[k], rw_o[k], m2r_o[k], mis_o[k]}) begin
        if (sb_q.size() == 0 || sb_q[0].inst != k) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output[%0d]: got alu=%h rd=%h, expected bubble", k,
                   alu_o[k], rd_o[k]);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk($sformatf("cycle[%0d]", k), 32'(cyc), 32'(e.cyc));
          chk($sformatf("read_data[%0d]", k), rd_o[k], e.rd);
          chk($sformatf("alu_result[%0d]", k), alu_o[k], e.alu);
          chk($sformatf("write_register[%0d]", k), 32'(wr_o[k]), 32'(e.wr));
          chk($sformatf("reg_write[%0d]", k), 32'(rw_o[k]), 32'(e.rw));
          chk($sformatf("mem_to_reg[%0d]", k), 32'(m2r_o[k]), 32'(e.m2r));
          chk($sformatf("misaligned[%0d]", k), 32'(mis_o[k]), 32'(e.mis));
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      dbg_a[k] = '0;
      idle(k);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_stall[%0d]", k), 32'(stall_o[k]), 32'd0);
      chk($sformatf("reset_outs[%0d]", k),
          32'({rd_o[k], alu_o[k], wr_o[k], rw_o[k], m2r_o[k], mis_o[k]} != '0), 32'd0);
    end
    @(posedge clk);
    #1;

    // ALU passthrough
    issue(0, 32'h0000_002A, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    // Store then load, LAT=1
    issue(0, 32'h10, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(0, 32'h10, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    dbg(0, 8'd4, 32'hDEAD_BEEF);

    // LAT=3 store then load, stall 1,1,0
    issue(1, 32'h20, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(1, 32'h20, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b0);
    dbg(1, 8'd8, 32'h1234_5678);

    // Misaligned store leaves RAM[4]; misaligned load suppresses reg_write
    issue(0, 32'h13, 32'hBAD0_BAD0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    dbg(0, 8'd4, 32'hDEAD_BEEF);
    issue(1, 32'h22, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);

    // LAT=4: prime RAM[2], then abort a store with reset in the 2nd stall cycle
    issue(2, 32'h08, 32'h1111_1111, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    dbg(2, 8'd2, 32'h1111_1111);
    alu_in[2] = 32'h08; rd2_in[2] = 32'hCAFE_F00D; mw_in[2] = 1'b1;
    @(negedge clk);
    chk("abort_stall_1", 32'(stall_o[2]), 32'd1);
    @(posedge clk);
    #1;
    rst[2] = 1'b1;
    @(negedge clk);
    chk("abort_stall_in_reset", 32'(stall_o[2]), 32'd0);
    @(posedge clk);
    #1;
    rst[2] = 1'b0;
    idle(2);
    @(negedge clk);
    chk("abort_stall_after", 32'(stall_o[2]), 32'd0);
    chk("abort_outs_zero",
        32'({rd_o[2], alu_o[2], wr_o[2], rw_o[2], m2r_o[2], mis_o[2]} != '0), 32'd0);
    @(posedge clk);
    #1;
    dbg(2, 8'd2, 32'h1111_1111);
    issue(2, 32'h08, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1111_1111, 1'b1, 1'b0);

    // Address wrap and read+write conflict
    issue(0, 32'h400, 32'h55AA_55AA, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    dbg(0, 8'd0, 32'h55AA_55AA);
    issue(0, 32'h0, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'h55AA_55AA, 1'b1, 1'b0);
    issue(0, 32'h404, 32'h0000_0077, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0);
    dbg(0, 8'd1, 32'h0000_0077);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
